// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and default widths for the CPU/DMA data-memory arbiter.
package data_mem_arbiter_pkg;

  localparam int unsigned DefAddrW = 22;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned WaitW    = 4;

  typedef enum logic {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_e;

  typedef enum logic {
    OwnerCpu = 1'b0,
    OwnerDma = 1'b1
  } owner_e;

endpackage

// File: rtl/dma_arb_policy.sv
// Winner selection between CPU and DMA: round-robin or CPU priority with a
// DMA anti-starvation counter.
module dma_arb_policy
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned CPU_PRIO = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_cpu_req,
  input  logic   i_dma_req,
  output logic   o_any_req,
  output owner_e o_winner
);

  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  owner_e           r_last;
  logic [WaitW-1:0] r_wait_cnt;
  logic             w_dma_wins;
  logic             w_contend_dma;

  // On contention the DMA wins either by turn (round-robin) or once it has waited long enough.
  always_comb begin
    w_contend_dma = (CPU_PRIO != 0) ? (r_wait_cnt == MaxWait) : (r_last == OwnerCpu);
    w_dma_wins    = i_dma_req && (!i_cpu_req || w_contend_dma);
    o_any_req     = i_cpu_req || i_dma_req;
    o_winner      = w_dma_wins ? OwnerDma : OwnerCpu;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= OwnerCpu;
      r_wait_cnt <= '0;
    end else begin
      if (o_any_req) begin
        r_last <= o_winner;
      end
      if (i_dma_req && !w_dma_wins) begin
        r_wait_cnt <= (r_wait_cnt == MaxWait) ? r_wait_cnt : r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU, DMA) arbiter onto a single-ported data memory: one access per
// cycle, registered address/data/write-enable and registered read data.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned CPU_PRIO = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_writeEnable,
  input  logic [DATA_W-1:0] mem_dataOut
);

  state_e            r_state;
  owner_e            r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_cpu_gnt;
  logic              r_dma_gnt;
  logic              r_cpu_rvalid;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic              w_any_req;
  owner_e            w_winner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_we;
  logic              w_cpu_rd_done;
  logic              w_dma_rd_done;

  dma_arb_policy #(
    .CPU_PRIO (CPU_PRIO),
    .MAX_WAIT (MAX_WAIT)
  ) u_policy (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_cpu_req (cpu_req),
    .i_dma_req (dma_req),
    .o_any_req (w_any_req),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_sel_addr    = (w_winner == OwnerDma) ? dma_addr  : cpu_addr;
    w_sel_wdata   = (w_winner == OwnerDma) ? dma_wdata : cpu_wdata;
    w_sel_we      = (w_winner == OwnerDma) ? dma_we    : cpu_we;
    w_cpu_rd_done = (r_state == StAccess) && (r_owner == OwnerCpu) && !r_we;
    w_dma_rd_done = (r_state == StAccess) && (r_owner == OwnerDma) && !r_we;
  end

  // Memory-side fields are zeroed in IDLE so the async reset also drops the write enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_owner      <= OwnerCpu;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_cpu_gnt    <= 1'b0;
      r_dma_gnt    <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_rd_done;
      r_dma_rvalid <= w_dma_rd_done;
      if (w_cpu_rd_done) r_cpu_rdata <= mem_dataOut;
      if (w_dma_rd_done) r_dma_rdata <= mem_dataOut;
      if (w_any_req) begin
        r_state   <= StAccess;
        r_owner   <= w_winner;
        r_addr    <= w_sel_addr;
        r_wdata   <= w_sel_wdata;
        r_we      <= w_sel_we;
        r_cpu_gnt <= (w_winner == OwnerCpu);
        r_dma_gnt <= (w_winner == OwnerDma);
      end else begin
        r_state   <= StIdle;
        r_addr    <= '0;
        r_wdata   <= '0;
        r_we      <= 1'b0;
        r_cpu_gnt <= 1'b0;
        r_dma_gnt <= 1'b0;
      end
    end
  end

  assign cpu_gnt         = r_cpu_gnt;
  assign dma_gnt         = r_dma_gnt;
  assign cpu_rvalid      = r_cpu_rvalid;
  assign dma_rvalid      = r_dma_rvalid;
  assign cpu_rdata       = r_cpu_rdata;
  assign dma_rdata       = r_dma_rdata;
  assign mem_address     = r_addr;
  assign mem_dataIn      = r_wdata;
  assign mem_writeEnable = r_we;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a CPU-priority instance and a round-robin instance
// share stimulus; directed steps followed by a randomized run against a reference model.
module tb_data_mem_arbiter;

  localparam int AW      = 22;
  localparam int DW      = 32;
  localparam int MaxWait = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, dma_req, cpu_we, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;

  logic          p_cpu_gnt, p_dma_gnt, p_cpu_rvalid, p_dma_rvalid, p_mem_we;
  logic [DW-1:0] p_cpu_rdata, p_dma_rdata, p_mem_din, p_mem_dout;
  logic [AW-1:0] p_mem_addr;
  logic          r_cpu_gnt, r_dma_gnt, r_cpu_rvalid, r_dma_rvalid, r_mem_we;
  logic [DW-1:0] r_cpu_rdata, r_dma_rdata, r_mem_din, r_mem_dout;
  logic [AW-1:0] r_mem_addr;

  logic [DW-1:0] mem_p [512];
  logic [DW-1:0] mem_r [512];
  bit            mem_ready;

  int n_pass;
  int n_total;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i * 32'h0101_0101) ^ 32'hA5A5_5A5A;
  endfunction

  // Behavioural memories; contents persist across arbiter reset.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) begin
        mem_p[i] <= init_val(i);
        mem_r[i] <= init_val(i);
      end
      mem_ready <= 1'b1;
    end else begin
      if (p_mem_we) mem_p[p_mem_addr[8:0]] <= p_mem_din;
      if (r_mem_we) mem_r[r_mem_addr[8:0]] <= r_mem_din;
    end
  end
  assign p_mem_dout = mem_p[p_mem_addr[8:0]];
  assign r_mem_dout = mem_r[r_mem_addr[8:0]];

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIO(1), .MAX_WAIT(MaxWait)) dut_p (
    .clk (clk), .reset_n (reset_n),
    .cpu_req (cpu_req), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_we (cpu_we),
    .cpu_gnt (p_cpu_gnt), .cpu_rvalid (p_cpu_rvalid), .cpu_rdata (p_cpu_rdata),
    .dma_req (dma_req), .dma_addr (dma_addr), .dma_wdata (dma_wdata), .dma_we (dma_we),
    .dma_gnt (p_dma_gnt), .dma_rvalid (p_dma_rvalid), .dma_rdata (p_dma_rdata),
    .mem_address (p_mem_addr), .mem_dataIn (p_mem_din), .mem_writeEnable (p_mem_we),
    .mem_dataOut (p_mem_dout)
  );

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_PRIO(0), .MAX_WAIT(MaxWait)) dut_r (
    .clk (clk), .reset_n (reset_n),
    .cpu_req (cpu_req), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_we (cpu_we),
    .cpu_gnt (r_cpu_gnt), .cpu_rvalid (r_cpu_rvalid), .cpu_rdata (r_cpu_rdata),
    .dma_req (dma_req), .dma_addr (dma_addr), .dma_wdata (dma_wdata), .dma_we (dma_we),
    .dma_gnt (r_dma_gnt), .dma_rvalid (r_dma_rvalid), .dma_rdata (r_dma_rdata),
    .mem_address (r_mem_addr), .mem_dataIn (r_mem_din), .mem_writeEnable (r_mem_we),
    .mem_dataOut (r_mem_dout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_cpu();
    cpu_req   = 1'b1;
    cpu_addr  = 22'h100 | AW'($urandom_range(0, 255));
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_wdata = $urandom;
  endtask

  task automatic new_dma();
    dma_req   = 1'b1;
    dma_addr  = 22'h100 | AW'($urandom_range(0, 255));
    dma_we    = 1'($urandom_range(0, 1));
    dma_wdata = $urandom;
  endtask

  // Grant orders with both requests held: 1 = DMA granted, 0 = CPU granted.
  bit rr_order [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  bit pr_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  // Reference model state.
  logic [DW-1:0] model_mem [512];
  int            m_streak;
  bit            m_prev_valid, m_prev_dma, m_prev_we;
  logic [AW-1:0] m_prev_addr;
  logic [DW-1:0] m_prev_wdata;
  logic [DW-1:0] exp_cpu_rdata, exp_dma_rdata;

  initial begin
    bit            c, d, valid, win_dma, cwe, dwe, cur_we, exp_crv, exp_drv;
    logic [AW-1:0] caddr, daddr, cur_addr;
    logic [DW-1:0] cwd, dwd, cur_wdata;

    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;
    for (int i = 0; i < 512; i++) model_mem[i] = init_val(i);

    #3;
    chk("rst_mem_we", p_mem_we, 1'b0);
    chk("rst_mem_addr", p_mem_addr, '0);
    chk("rst_mem_din", p_mem_din, '0);
    chk("rst_gnts", {p_cpu_gnt, p_dma_gnt, r_cpu_gnt, r_dma_gnt}, 4'b0);
    chk("rst_rvalids", {p_cpu_rvalid, p_dma_rvalid}, 2'b0);
    chk("rst_rdata", {p_cpu_rdata, p_dma_rdata}, 64'h0);
    repeat (2) tick();
    reset_n = 1'b1;

    // CPU write then read-back.
    cpu_req = 1'b1; cpu_addr = 22'h10; cpu_wdata = 32'hDEADBEEF; cpu_we = 1'b1;
    tick();
    chk("wr_cpu_gnt", {p_cpu_gnt, p_dma_gnt, r_cpu_gnt, r_dma_gnt}, 4'b1010);
    chk("wr_mem_we", {p_mem_we, r_mem_we}, 2'b11);
    chk("wr_mem_addr", p_mem_addr, 22'h10);
    chk("wr_mem_din", p_mem_din, 32'hDEADBEEF);
    cpu_req = 1'b0;
    tick();
    chk("wr_no_rvalid", {p_cpu_rvalid, r_cpu_rvalid}, 2'b00);
    chk("wr_idle", {p_cpu_gnt, p_mem_we, 22'(p_mem_addr)}, '0);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    chk("rd_cpu_gnt", {p_cpu_gnt, p_mem_we}, 2'b10);
    cpu_req = 1'b0;
    tick();
    chk("rd_rvalid", {p_cpu_rvalid, r_cpu_rvalid, p_dma_rvalid}, 3'b110);
    chk("rd_rdata_p", p_cpu_rdata, 32'hDEADBEEF);
    chk("rd_rdata_r", r_cpu_rdata, 32'hDEADBEEF);
    tick();
    chk("rd_rvalid_pulse", p_cpu_rvalid, 1'b0);
    chk("rd_rdata_hold", p_cpu_rdata, 32'hDEADBEEF);

    // Sustained contention: round-robin vs CPU priority with anti-starvation.
    cpu_req = 1'b1; cpu_addr = 22'h20; cpu_we = 1'b0;
    dma_req = 1'b1; dma_addr = 22'h30; dma_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), {r_dma_gnt, r_cpu_gnt}, {rr_order[i], !rr_order[i]});
      chk($sformatf("pr_grant%0d", i), {p_dma_gnt, p_cpu_gnt}, {pr_order[i], !pr_order[i]});
      chk($sformatf("wait_le_max%0d", i), dut_p.u_policy.r_wait_cnt <= 4'(MaxWait), 1'b1);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    chk("cont_idle", {p_cpu_gnt, p_dma_gnt, r_cpu_gnt, r_dma_gnt}, 4'b0);
    chk("cont_rvalid", {p_dma_rvalid, p_cpu_rvalid, r_cpu_rvalid, r_dma_rvalid}, 4'b1010);
    chk("cont_dma_rdata", p_dma_rdata, init_val(32'h30));
    chk("cont_cpu_rdata", r_cpu_rdata, init_val(32'h20));
    tick();

    // DMA request withdrawn before it is ever granted.
    cpu_req = 1'b1; dma_req = 1'b1;
    tick();
    chk("drop_c1", {p_cpu_gnt, p_dma_gnt}, 2'b10);
    tick();
    chk("drop_c2", {p_cpu_gnt, p_dma_gnt}, 2'b10);
    chk("drop_wait2", dut_p.u_policy.r_wait_cnt, 4'd2);
    dma_req = 1'b0;
    tick();
    chk("drop_c3", {p_cpu_gnt, p_dma_gnt}, 2'b10);
    chk("drop_wait0", dut_p.u_policy.r_wait_cnt, 4'd0);
    cpu_req = 1'b0;
    tick();
    tick();
    chk("drop_no_dma_rvalid", p_dma_rvalid, 1'b0);

    // Reset in the middle of a write access.
    cpu_req = 1'b1; cpu_addr = 22'h40; cpu_wdata = 32'h1234_5678; cpu_we = 1'b1;
    tick();
    chk("rstw_we_before", {p_mem_we, r_mem_we}, 2'b11);
    #2;
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("rstw_we_drop", {p_mem_we, r_mem_we}, 2'b00);
    chk("rstw_gnt_drop", {p_cpu_gnt, r_cpu_gnt}, 2'b00);
    chk("rstw_addr", p_mem_addr, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstw_quiet%0d", i),
          {p_cpu_gnt, p_dma_gnt, p_cpu_rvalid, p_dma_rvalid, p_mem_we, r_mem_we}, 6'b0);
    end
    chk("rstw_rdata_clr", {p_cpu_rdata, r_cpu_rdata}, 64'h0);
    chk("rstw_no_commit", mem_p[9'h40], init_val(32'h40));

    // Randomized traffic on the CPU-priority instance against the reference model.
    m_streak = 0; m_prev_valid = 1'b0; m_prev_dma = 1'b0; m_prev_we = 1'b0;
    m_prev_addr = '0; m_prev_wdata = '0;
    exp_cpu_rdata = '0; exp_dma_rdata = '0;
    for (int n = 0; n < 600; n++) begin
      c = cpu_req; caddr = cpu_addr; cwe = cpu_we; cwd = cpu_wdata;
      d = dma_req; daddr = dma_addr; dwe = dma_we; dwd = dma_wdata;
      tick();
      exp_crv = 1'b0; exp_drv = 1'b0;
      if (m_prev_valid) begin
        if (m_prev_we) begin
          model_mem[m_prev_addr[8:0]] = m_prev_wdata;
        end else if (m_prev_dma) begin
          exp_drv = 1'b1;
          exp_dma_rdata = model_mem[m_prev_addr[8:0]];
        end else begin
          exp_crv = 1'b1;
          exp_cpu_rdata = model_mem[m_prev_addr[8:0]];
        end
      end
      valid   = c | d;
      win_dma = d && (!c || m_streak == MaxWait);
      if (d && !win_dma) m_streak = (m_streak < MaxWait) ? m_streak + 1 : MaxWait;
      else m_streak = 0;
      cur_addr  = !valid ? '0 : (win_dma ? daddr : caddr);
      cur_we    = valid && (win_dma ? dwe : cwe);
      cur_wdata = win_dma ? dwd : cwd;

      chk("rnd_gnts", {p_cpu_gnt, p_dma_gnt}, {valid && !win_dma, valid && win_dma});
      chk("rnd_mem_we", p_mem_we, cur_we);
      chk("rnd_mem_addr", p_mem_addr, cur_addr);
      if (valid) chk("rnd_mem_din", p_mem_din, cur_wdata);
      chk("rnd_rvalid", {p_cpu_rvalid, p_dma_rvalid}, {exp_crv, exp_drv});
      chk("rnd_cpu_rdata", p_cpu_rdata, exp_cpu_rdata);
      chk("rnd_dma_rdata", p_dma_rdata, exp_dma_rdata);

      m_prev_valid = valid; m_prev_dma = win_dma; m_prev_we = cur_we;
      m_prev_addr = cur_addr; m_prev_wdata = cur_wdata;

      if (!cpu_req || (valid && !win_dma)) begin
        if ($urandom_range(0, 99) < 55) new_cpu();
        else cpu_req = 1'b0;
      end
      if (!dma_req || (valid && win_dma)) begin
        if ($urandom_range(0, 99) < 55) new_dma();
        else dma_req = 1'b0;
      end else if ($urandom_range(0, 99) < 10) begin
        dma_req = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, data-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter CPU_PRIO, default 1; 1 = CPU fixed priority with DMA anti-starvation, 0 = round-robin.
REQ-004 SHALL have parameter MAX_WAIT, default 4, range 1..15; consecutive DMA lost-arbitration cycles before the DMA port is forced to win.
REQ-005 SHALL have ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req / dma_req  in  1  access request; held with its fields stable until the matching gnt.
- cpu_addr / dma_addr  in  ADDR_W  word address.
- cpu_wdata / dma_wdata  in  DATA_W  write data.
- cpu_we / dma_we  in  1  1 = write, 0 = read.
- cpu_gnt / dma_gnt  out  1  one-cycle pulse; access performed this cycle.
- cpu_rvalid / dma_rvalid  out  1  one-cycle pulse; read data valid.
- cpu_rdata / dma_rdata  out  DATA_W  registered read data.
- mem_address  out  ADDR_W  to the data memory address input.
- mem_dataIn  out  DATA_W  to the data memory write-data input.
- mem_writeEnable  out  1  to the data memory write enable.
- mem_dataOut  in  DATA_W  combinational read data from the data memory.

Function
REQ-006 SHALL implement FSM states IDLE and ACCESS, plus a registered owner bit (0 = CPU, 1 = DMA).
REQ-007 In IDLE or ACCESS, if any req is high at a rising edge, SHALL pick a winner per REQ-010/011 and enter or stay in ACCESS with owner = winner; otherwise SHALL go to IDLE.
REQ-008 In ACCESS, SHALL drive mem_address, mem_dataIn and mem_writeEnable from the owner's registered addr, wdata and we, and pulse the owner's gnt for exactly this cycle.
REQ-009 In IDLE, SHALL drive mem_writeEnable = 0 and mem_address = 0.
REQ-010 Round-robin (CPU_PRIO = 0): on contention, the port not served last SHALL win; after reset, the CPU is treated as last served so the DMA wins the first contention.
REQ-011 CPU priority (CPU_PRIO = 1): the CPU SHALL win contention unless wait_cnt = MAX_WAIT, in which case the DMA SHALL win.
REQ-012 wait_cnt (4-bit) SHALL increment, saturating at MAX_WAIT, each arbitration in which dma_req is high and the DMA loses; it SHALL clear when the DMA wins or dma_req is low.
REQ-013 Latency: request sampled at edge N, gnt and memory access in cycle N+1, write committed at edge N+2.
REQ-014 For a read, SHALL capture mem_dataOut into the owner's rdata at the end of the ACCESS cycle and pulse that port's rvalid in the following cycle; writes SHALL produce no rvalid.
REQ-015 rdata SHALL hold its value until the next read for that port.
REQ-016 Throughput SHALL be one access per cycle; back-to-back ACCESS cycles are allowed, including consecutive grants to the same port.
REQ-017 A requester whose req is still high in the cycle its gnt pulses SHALL be treated as issuing a new request.
REQ-018 A req that drops before its grant SHALL be discarded with no memory side effect.
REQ-019 mem_writeEnable SHALL never be high outside ACCESS; at most one gnt SHALL be high in any cycle.

Reset
REQ-020 While reset_n = 0, SHALL asynchronously force: state IDLE, owner 0, last-served CPU, wait_cnt 0, all gnt/rvalid 0, rdata 0, mem_writeEnable 0, mem_address 0, mem_dataIn 0.
REQ-021 Reset asserted during ACCESS SHALL abort the access: no rvalid for it, and mem_writeEnable SHALL drop immediately.

Structure
REQ-022 The shared package SHALL hold the state enum (IDLE, ACCESS), the owner encoding and the default ADDR_W/DATA_W constants.
REQ-023 One sub-module, dma_arb_policy, SHALL hold winner selection plus wait_cnt; the FSM, datapath mux and read registers SHALL stay in the top.

Verification
REQ-024 CPU write only: addr 0x000010, wdata 0xDEADBEEF, we 1 at edge 0 -> cpu_gnt and mem_writeEnable high in cycle 1 with mem_address 0x10; no cpu_rvalid.
REQ-025 CPU read after REQ-024: addr 0x10, we 0 -> cpu_gnt in cycle 1, cpu_rvalid in cycle 2 with cpu_rdata 0xDEADBEEF.
REQ-026 Round-robin (CPU_PRIO 0), both reqs held high for 4 grants -> grant order DMA, CPU, DMA, CPU.
REQ-027 Starvation (CPU_PRIO 1, MAX_WAIT 4), both reqs held high -> grant order CPU x4, DMA, CPU x4, DMA; wait_cnt never exceeds 4.
REQ-028 Reset mid-write: reset_n low in an ACCESS cycle with we 1 -> mem_writeEnable 0 within the same cycle; no gnt or rvalid until the first post-reset request.
REQ-029 DMA req drops before grant while the CPU is granted -> no dma_gnt, and wait_cnt returns to 0.
